// File: rtl/soc_ram_arbiter.sv
// Shares one single-port SoC RAM between the instruction-fetch port (m0) and the
// data port (m1): data wins ties, and a starvation counter guarantees m0 progress.
module soc_ram_arbiter #(
    parameter int p_starve_limit = 4,
    parameter int p_cnt_width    = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,

    input  logic                   i_m0_req,
    input  logic [31:2]            i_m0_addr,
    input  logic                   i_m0_wr_en,
    input  logic [3:0]             i_m0_be,
    input  logic [31:0]            i_m0_wr_data,
    output logic                   o_m0_gnt,
    output logic                   o_m0_rvalid,
    output logic [31:0]            o_m0_rd_data,

    input  logic                   i_m1_req,
    input  logic [31:2]            i_m1_addr,
    input  logic                   i_m1_wr_en,
    input  logic [3:0]             i_m1_be,
    input  logic [31:0]            i_m1_wr_data,
    output logic                   o_m1_gnt,
    output logic                   o_m1_rvalid,
    output logic [31:0]            o_m1_rd_data,

    output logic [31:2]            o_ram_addr,
    output logic [3:0]             o_ram_be,
    output logic                   o_ram_wr_en,
    output logic [31:0]            o_ram_wr_data,
    output logic                   o_ram_rd_en,
    input  logic [31:0]            i_ram_rd_data,

    output logic                   o_dbg_force_m0,
    output logic [p_cnt_width-1:0] o_dbg_starve_cnt
);

    // Handshake: a requester raises req with stable addr/wr_en/be/wr_data and holds them
    // until gnt is seen high in the same cycle; gnt=1 means the access was issued to the
    // RAM that cycle. Reads return with rvalid exactly one cycle later; writes end at gnt.

    typedef enum logic {
        st_data_prio = 1'b0,
        st_force_m0  = 1'b1
    } prio_state_t;

    localparam logic [p_cnt_width-1:0] lc_limit = p_cnt_width'(p_starve_limit);

    prio_state_t            state_q;
    logic [p_cnt_width-1:0] starve_cnt_q;
    logic [p_cnt_width-1:0] starve_cnt_d;
    logic                   gnt_m0;
    logic                   gnt_m1;
    logic                   m0_rvalid_q;
    logic                   m1_rvalid_q;

    // Reset gates the grants combinationally so nothing reaches the RAM while it is held.
    always_comb begin
        gnt_m0 = 1'b0;
        gnt_m1 = 1'b0;
        if (i_rst_n) begin
            if (i_m0_req && (!i_m1_req || state_q == st_force_m0)) begin
                gnt_m0 = 1'b1;
            end else if (i_m1_req) begin
                gnt_m1 = 1'b1;
            end
        end
    end

    always_comb begin
        starve_cnt_d = '0;
        if (i_m0_req && !gnt_m0) begin
            starve_cnt_d = (starve_cnt_q >= lc_limit) ? lc_limit : starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= st_data_prio;
            starve_cnt_q <= '0;
            m0_rvalid_q  <= 1'b0;
            m1_rvalid_q  <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            m0_rvalid_q  <= gnt_m0 & ~i_m0_wr_en;
            m1_rvalid_q  <= gnt_m1 & ~i_m1_wr_en;
            case (state_q)
                st_data_prio: begin
                    if (starve_cnt_d == lc_limit) begin
                        state_q <= st_force_m0;
                    end
                end
                st_force_m0: begin
                    if (gnt_m0 || !i_m0_req) begin
                        state_q <= st_data_prio;
                    end
                end
                default: state_q <= st_data_prio;
            endcase
        end
    end

    // Idle cycles present m1's fields so the RAM inputs are never undefined.
    assign o_ram_addr    = gnt_m0 ? i_m0_addr    : i_m1_addr;
    assign o_ram_be      = gnt_m0 ? i_m0_be      : i_m1_be;
    assign o_ram_wr_data = gnt_m0 ? i_m0_wr_data : i_m1_wr_data;
    assign o_ram_wr_en   = (gnt_m0 & i_m0_wr_en)  | (gnt_m1 & i_m1_wr_en);
    assign o_ram_rd_en   = (gnt_m0 & ~i_m0_wr_en) | (gnt_m1 & ~i_m1_wr_en);

    assign o_m0_gnt      = gnt_m0;
    assign o_m1_gnt      = gnt_m1;
    assign o_m0_rvalid   = m0_rvalid_q;
    assign o_m1_rvalid   = m1_rvalid_q;
    assign o_m0_rd_data  = i_ram_rd_data;
    assign o_m1_rd_data  = i_ram_rd_data;

    assign o_dbg_force_m0   = (state_q == st_force_m0);
    assign o_dbg_starve_cnt = starve_cnt_q;

endmodule
